// File: rtl/bar_display_pkg.sv
// Shared types and saturating helpers for the bar display pipeline.
package bar_display_pkg;

   localparam int BAR_W     = 7;
   localparam int DEF_COL_W = 6;

   typedef enum logic {
      IDLE,
      SWEEP
   } state_t;

   function automatic logic [BAR_W-1:0] sat_sub(input logic [BAR_W-1:0] a,
                                                input logic [BAR_W-1:0] b);
      return (a > b) ? (a - b) : '0;
   endfunction

   function automatic logic [BAR_W-1:0] bar_max(input logic [BAR_W-1:0] a,
                                                input logic [BAR_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bar_decay_calc.sv
// Per-column frame decay: next level, and next peak/hold when PEAK_HOLD_EN is defined.
module bar_decay_calc
   import bar_display_pkg::*;
#(
   parameter int DECAY_STEP = 2
`ifdef PEAK_HOLD_EN
   ,
   parameter int PEAK_FALL  = 1,
   parameter int HOLD_W     = 5
`endif
) (
   input  logic [BAR_W-1:0]  level,
   output logic [BAR_W-1:0]  level_next
`ifdef PEAK_HOLD_EN
   ,
   input  logic [BAR_W-1:0]  peak,
   input  logic [HOLD_W-1:0] hold,
   output logic [BAR_W-1:0]  peak_next,
   output logic [HOLD_W-1:0] hold_next
`endif
);

   localparam logic [BAR_W-1:0] STEP = BAR_W'(DECAY_STEP);
`ifdef PEAK_HOLD_EN
   localparam logic [BAR_W-1:0] FALL = BAR_W'(PEAK_FALL);
`endif

   // The peak never drops below the freshly decayed level, keeping peak >= level.
   always_comb begin
      level_next = sat_sub(level, STEP);
`ifdef PEAK_HOLD_EN
      peak_next  = peak;
      hold_next  = hold;
      if (hold != '0) begin
         hold_next = hold - 1'b1;
      end else begin
         peak_next = bar_max(sat_sub(peak, FALL), level_next);
      end
`endif
   end

endmodule

// File: rtl/bar_peak_hold.sv
// Per-column fast-attack/slow-decay display levels with optional peak-hold markers.
// Define PEAK_HOLD_EN to build the peak/hold arrays; otherwise RdPeak is tied to 0.
module bar_peak_hold
   import bar_display_pkg::*;
#(
   parameter int NUM_COLS   = 64,
   parameter int COL_W      = DEF_COL_W,
   parameter int DECAY_STEP = 2,
   parameter int PEAK_HOLD  = 30,
   parameter int HOLD_W     = 5,
   parameter int PEAK_FALL  = 1
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             FrameTick,
   input  logic             InValid,
   output logic             InReady,
   input  logic [COL_W-1:0] InCol,
   input  logic [BAR_W-1:0] InBar,
   input  logic [COL_W-1:0] RdCol,
   output logic [BAR_W-1:0] RdBar,
   output logic [BAR_W-1:0] RdPeak,
   output logic             Busy
);

   localparam logic [COL_W-1:0] LAST_COL   = COL_W'(NUM_COLS - 1);
   localparam logic [COL_W:0]   COLS_LIMIT = (COL_W+1)'(NUM_COLS);

   // Elaboration-time parameter range guard.
   if (NUM_COLS < 2 || NUM_COLS > (1 << COL_W) || PEAK_HOLD < 1 ||
       PEAK_HOLD >= (1 << HOLD_W) || DECAY_STEP < 0 || DECAY_STEP >= (1 << BAR_W) ||
       PEAK_FALL < 0 || PEAK_FALL >= (1 << BAR_W)) begin : g_bad_params
      $error("bar_peak_hold: parameter out of range");
   end

   state_t           state;
   state_t           state_next;
   logic             pending;
   logic             start_sweep;
   logic [COL_W-1:0] sweep_idx;
   logic             accept;
   logic             in_range;
   logic             rd_in_range;

   logic [BAR_W-1:0] level [NUM_COLS];
   logic [BAR_W-1:0] sweep_level;
   logic [BAR_W-1:0] level_next;

   always_comb begin
      state_next  = state;
      InReady     = 1'b0;
      Busy        = 1'b0;
      start_sweep = 1'b0;
      case (state)
         IDLE: begin
            InReady = 1'b1;
            if (pending && !InValid) begin
               start_sweep = 1'b1;
               state_next  = SWEEP;
            end
         end
         SWEEP: begin
            Busy = 1'b1;
            if (sweep_idx == LAST_COL) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign accept      = InValid & InReady;
   assign in_range    = {1'b0, InCol} < COLS_LIMIT;
   assign rd_in_range = {1'b0, RdCol} < COLS_LIMIT;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A tick arriving on the very cycle a sweep starts is kept as a fresh request.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         pending <= 1'b0;
      end else begin
         pending <= FrameTick | (pending & ~start_sweep);
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         sweep_idx <= '0;
      end else if (state == SWEEP) begin
         sweep_idx <= (sweep_idx == LAST_COL) ? '0 : sweep_idx + 1'b1;
      end
   end

   assign sweep_level = level[sweep_idx];

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_COLS; i++) level[i] <= '0;
      end else if (state == SWEEP) begin
         level[sweep_idx] <= level_next;
      end else if (accept && in_range) begin
         level[InCol] <= bar_max(level[InCol], InBar);
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         RdBar <= '0;
      end else begin
         RdBar <= rd_in_range ? level[RdCol] : '0;
      end
   end

`ifdef PEAK_HOLD_EN
   logic [BAR_W-1:0]  peak [NUM_COLS];
   logic [HOLD_W-1:0] hold [NUM_COLS];
   logic [BAR_W-1:0]  sweep_peak;
   logic [HOLD_W-1:0] sweep_hold;
   logic [BAR_W-1:0]  peak_next;
   logic [HOLD_W-1:0] hold_next;

   assign sweep_peak = peak[sweep_idx];
   assign sweep_hold = hold[sweep_idx];

   // An equal bar re-arms the hold timer, so a steady tone keeps its marker up.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_COLS; i++) begin
            peak[i] <= '0;
            hold[i] <= '0;
         end
      end else if (state == SWEEP) begin
         peak[sweep_idx] <= peak_next;
         hold[sweep_idx] <= hold_next;
      end else if (accept && in_range && (InBar >= peak[InCol])) begin
         peak[InCol] <= InBar;
         hold[InCol] <= HOLD_W'(PEAK_HOLD);
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         RdPeak <= '0;
      end else begin
         RdPeak <= rd_in_range ? peak[RdCol] : '0;
      end
   end

   bar_decay_calc #(
      .DECAY_STEP (DECAY_STEP),
      .PEAK_FALL  (PEAK_FALL),
      .HOLD_W     (HOLD_W)
   ) u_decay (
      .level      (sweep_level),
      .level_next (level_next),
      .peak       (sweep_peak),
      .hold       (sweep_hold),
      .peak_next  (peak_next),
      .hold_next  (hold_next)
   );
`else
   assign RdPeak = '0;

   bar_decay_calc #(
      .DECAY_STEP (DECAY_STEP)
   ) u_decay (
      .level      (sweep_level),
      .level_next (level_next)
   );
`endif

endmodule

// File: tb/tb_bar_peak_hold.sv
// Randomised and directed bench for bar_peak_hold against a per-column behavioural model.
module tb_bar_peak_hold;

   localparam int NUM_COLS   = 64;
   localparam int DECAY_STEP = 2;
   localparam int PEAK_HOLD  = 30;
   localparam int PEAK_FALL  = 1;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       FrameTick;
   logic       InValid;
   logic       InReady;
   logic [5:0] InCol;
   logic [6:0] InBar;
   logic [5:0] RdCol;
   logic [6:0] RdBar;
   logic [6:0] RdPeak;
   logic       Busy;

   int checks   = 0;
   int failures = 0;

   int m_level [NUM_COLS];
   int m_peak  [NUM_COLS];
   int m_hold  [NUM_COLS];

   always #5 Clock = ~Clock;

   bar_peak_hold dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .FrameTick (FrameTick),
      .InValid   (InValid),
      .InReady   (InReady),
      .InCol     (InCol),
      .InBar     (InBar),
      .RdCol     (RdCol),
      .RdBar     (RdBar),
      .RdPeak    (RdPeak),
      .Busy      (Busy)
   );

   // Model: levels rise to any larger bar, fall by DECAY_STEP per frame, floor at 0.
   function automatic void m_clear();
      for (int c = 0; c < NUM_COLS; c++) begin
         m_level[c] = 0;
         m_peak[c]  = 0;
         m_hold[c]  = 0;
      end
   endfunction

   function automatic void m_input(int c, int b);
      if (b > m_level[c]) m_level[c] = b;
      if (b >= m_peak[c]) begin
         m_peak[c] = b;
         m_hold[c] = PEAK_HOLD;
      end
   endfunction

   function automatic void m_sweep();
      for (int c = 0; c < NUM_COLS; c++) begin
         int nl;
         int fp;
         nl = m_level[c] - DECAY_STEP;
         if (nl < 0) nl = 0;
         if (m_hold[c] > 0) begin
            m_hold[c] = m_hold[c] - 1;
         end else begin
            fp = m_peak[c] - PEAK_FALL;
            if (fp < 0) fp = 0;
            m_peak[c] = (fp > nl) ? fp : nl;
         end
         m_level[c] = nl;
      end
   endfunction

   function automatic int exp_peak(int c);
`ifdef PEAK_HOLD_EN
      return m_peak[c];
`else
      return (c < 0) ? 1 : 0;
`endif
   endfunction

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic read_col(input int c, output int bar, output int pk);
      RdCol = 6'(c);
      tick();
      bar = int'(RdBar);
      pk  = int'(RdPeak);
   endtask

   task automatic wait_sweep(output int lead, output int busy_cycles);
      lead        = 0;
      busy_cycles = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (Busy) busy_cycles++;
         else if (busy_cycles > 0) break;
         else lead++;
      end
   endtask

   task automatic applyStimulus(input int c, input int b, input bit tick_too);
      InValid   = 1'b1;
      InCol     = 6'(c);
      InBar     = 7'(b);
      FrameTick = tick_too;
      tick();
      InValid   = 1'b0;
      FrameTick = 1'b0;
      m_input(c, b);
   endtask

   task automatic test_reset();
      int bar, pk;
      Reset = 1'b1; FrameTick = 1'b0; InValid = 1'b0;
      InCol = '0; InBar = '0; RdCol = '0;
      repeat (3) tick();
      checks++;
      if (InReady !== 1'b1 || Busy !== 1'b0 || RdBar !== 7'd0 || RdPeak !== 7'd0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: got ready=%b busy=%b bar=%0d peak=%0d, expected 1 0 0 0",
                  InReady, Busy, RdBar, RdPeak);
      end
      Reset = 1'b0;
      m_clear();
      tick();
      for (int c = 0; c < NUM_COLS; c++) begin
         read_col(c, bar, pk);
         checks++;
         if (bar !== 0 || pk !== 0) begin
            failures++;
            $display("[TB] FAIL reset_col%0d: got bar=%0d peak=%0d, expected 0 0", c, bar, pk);
         end
      end
   endtask

   task automatic test_input_latency();
      int bar, pk, old_bar;
      RdCol   = 6'd5;
      old_bar = m_level[5];
      applyStimulus(5, 100, 1'b0);
      checks++;
      if (int'(RdBar) !== old_bar) begin
         failures++;
         $display("[TB] FAIL latency_edge1: got bar=%0d, expected %0d", RdBar, old_bar);
      end
      tick();
      checks++;
      if (int'(RdBar) !== m_level[5] || int'(RdPeak) !== exp_peak(5)) begin
         failures++;
         $display("[TB] FAIL latency_edge2: got bar=%0d peak=%0d, expected %0d %0d",
                  RdBar, RdPeak, m_level[5], exp_peak(5));
      end
      applyStimulus(5, 40, 1'b0);
      applyStimulus(7, 1, 1'b0);
      read_col(5, bar, pk);
      checks++;
      if (bar !== m_level[5] || pk !== exp_peak(5)) begin
         failures++;
         $display("[TB] FAIL attack_smaller_bar: got bar=%0d peak=%0d, expected %0d %0d",
                  bar, pk, m_level[5], exp_peak(5));
      end
   endtask

   task automatic test_sweep_decay();
      int lead, n, bar, pk;
      for (int k = 1; k <= PEAK_HOLD + 1; k++) begin
         FrameTick = 1'b1;
         tick();
         FrameTick = 1'b0;
         wait_sweep(lead, n);
         m_sweep();
         checks++;
         if (n !== NUM_COLS || lead !== 0) begin
            failures++;
            $display("[TB] FAIL sweep%0d_length: got busy=%0d lead=%0d, expected %0d 0",
                     k, n, lead, NUM_COLS);
         end
         read_col(5, bar, pk);
         checks++;
         if (bar !== m_level[5] || pk !== exp_peak(5)) begin
            failures++;
            $display("[TB] FAIL sweep%0d_col5: got bar=%0d peak=%0d, expected %0d %0d",
                     k, bar, pk, m_level[5], exp_peak(5));
         end
         if (k == 1) begin
            read_col(7, bar, pk);
            checks++;
            if (bar !== m_level[7] || pk !== exp_peak(7)) begin
               failures++;
               $display("[TB] FAIL floor_col7: got bar=%0d peak=%0d, expected %0d %0d",
                        bar, pk, m_level[7], exp_peak(7));
            end
         end
      end
   endtask

   task automatic test_coincident();
      int lead, n, bar, pk;
      RdCol = 6'd3;
      applyStimulus(3, 50, 1'b1);
      checks++;
      if (InReady !== 1'b1 || Busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL coincident_decision: got ready=%b busy=%b, expected 1 0", InReady, Busy);
      end
      wait_sweep(lead, n);
      m_sweep();
      checks++;
      if (n !== NUM_COLS || lead !== 0) begin
         failures++;
         $display("[TB] FAIL coincident_sweep: got busy=%0d lead=%0d, expected %0d 0", n, lead, NUM_COLS);
      end
      read_col(3, bar, pk);
      checks++;
      if (bar !== m_level[3] || pk !== exp_peak(3)) begin
         failures++;
         $display("[TB] FAIL coincident_col3: got bar=%0d peak=%0d, expected %0d %0d",
                  bar, pk, m_level[3], exp_peak(3));
      end
   endtask

   task automatic test_random();
      int lead, n, bar, pk, len, tick_at, c, b, sel;
      for (int r = 0; r < 4; r++) begin
         len     = $urandom_range(5, 20);
         tick_at = $urandom_range(0, len - 1);
         for (int i = 0; i < len; i++) begin
            c   = $urandom_range(0, NUM_COLS - 1);
            sel = $urandom_range(0, 7);
            b   = (sel == 0) ? 127 : (sel == 1) ? 0 : $urandom_range(0, 127);
            checks++;
            if (InReady !== 1'b1) begin
               failures++;
               $display("[TB] FAIL random%0d_ready: got %b, expected 1", r, InReady);
            end
            applyStimulus(c, b, i == tick_at);
         end
         wait_sweep(lead, n);
         m_sweep();
         checks++;
         if (n !== NUM_COLS) begin
            failures++;
            $display("[TB] FAIL random%0d_sweep: got busy=%0d, expected %0d", r, n, NUM_COLS);
         end
         for (int k = 0; k < NUM_COLS; k++) begin
            read_col(k, bar, pk);
            checks++;
            if (bar !== m_level[k] || pk !== exp_peak(k)) begin
               failures++;
               $display("[TB] FAIL random%0d_col%0d: got bar=%0d peak=%0d, expected %0d %0d",
                        r, k, bar, pk, m_level[k], exp_peak(k));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit busy_log [200];
      bit rdy_log  [200];
      int run1, gap, run2, extra, idx, bar, pk, c;
      bit gap_ready;
      FrameTick = 1'b1;
      tick();
      for (int i = 0; i < 200; i++) begin
         FrameTick   = (i == 10 || i == 30);
         tick();
         busy_log[i] = Busy;
         rdy_log[i]  = InReady;
      end
      FrameTick = 1'b0;
      idx = 0; run1 = 0; gap = 0; run2 = 0; extra = 0; gap_ready = 1'b1;
      while (idx < 200 && busy_log[idx]) begin run1++; idx++; end
      while (idx < 200 && !busy_log[idx]) begin
         gap_ready = gap_ready & rdy_log[idx];
         gap++; idx++;
      end
      while (idx < 200 && busy_log[idx]) begin run2++; idx++; end
      for (int i = idx; i < 200; i++) if (busy_log[i]) extra++;
      checks++;
      if (run1 !== NUM_COLS || gap !== 1 || !gap_ready || run2 !== NUM_COLS || extra !== 0) begin
         failures++;
         $display("[TB] FAIL back_to_back: got run1=%0d gap=%0d ready=%b run2=%0d extra=%0d, expected %0d 1 1 %0d 0",
                  run1, gap, gap_ready, run2, extra, NUM_COLS, NUM_COLS);
      end
      m_sweep();
      m_sweep();
      for (int k = 0; k < 8; k++) begin
         c = $urandom_range(0, NUM_COLS - 1);
         read_col(c, bar, pk);
         checks++;
         if (bar !== m_level[c] || pk !== exp_peak(c)) begin
            failures++;
            $display("[TB] FAIL b2b_col%0d: got bar=%0d peak=%0d, expected %0d %0d",
                     c, bar, pk, m_level[c], exp_peak(c));
         end
      end
   endtask

   task automatic test_reset_mid_sweep();
      int bar, pk, late_busy;
      applyStimulus(40, 120, 1'b0);
      RdCol     = 6'd40;
      FrameTick = 1'b1;
      tick();
      FrameTick = 1'b0;
      tick();
      for (int i = 0; i < 20; i++) begin
         FrameTick = (i == 5);
         tick();
      end
      FrameTick = 1'b0;
      Reset = 1'b1;
      #1;
      checks++;
      if (Busy !== 1'b0 || InReady !== 1'b1 || RdBar !== 7'd0 || RdPeak !== 7'd0) begin
         failures++;
         $display("[TB] FAIL reset_mid_sweep: got busy=%b ready=%b bar=%0d peak=%0d, expected 0 1 0 0",
                  Busy, InReady, RdBar, RdPeak);
      end
      repeat (2) tick();
      Reset = 1'b0;
      m_clear();
      late_busy = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (Busy) late_busy++;
      end
      checks++;
      if (late_busy !== 0) begin
         failures++;
         $display("[TB] FAIL pending_lost: got %0d busy cycles after reset, expected 0", late_busy);
      end
      for (int c = 0; c < NUM_COLS; c += 4) begin
         read_col(c, bar, pk);
         checks++;
         if (bar !== m_level[c] || pk !== exp_peak(c)) begin
            failures++;
            $display("[TB] FAIL post_reset_col%0d: got bar=%0d peak=%0d, expected 0 0", c, bar, pk);
         end
      end
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_input_latency();
      test_sweep_decay();
      test_coincident();
      test_random();
      test_back_to_back();
      test_reset_mid_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
